// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a framed byte stream and
// holds the core in reset until a frame with a good checksum has landed.
// Frame: LEN_LO, LEN_HI, LEN little-endian 32-bit words, XOR checksum byte.

module imem_loader #(
    // Word-address width of imem; the length compare assumes ADDR_WIDTH <= 15
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    // Largest legal word count; 17 bits so 2**ADDR_WIDTH itself fits
    localparam logic [16:0] MaxLen = 17'(2 ** ADDR_WIDTH);

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           buf_q, buf_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  accept;
    logic [15:0]           len_full;
    logic [ADDR_WIDTH:0]   word_cnt_inc;

    // Status outputs decoded straight from the state register
    always_comb begin
        rx_ready   = (state_q == StLen0) || (state_q == StLen1) ||
                     (state_q == StData) || (state_q == StCheck);
        busy       = rx_ready;
        done       = (state_q == StDone);
        error      = (state_q == StError);
        core_reset = (state_q != StDone);
        imem_we    = we_q;
        imem_addr  = addr_q;
        imem_wdata = wdata_q;
    end

    // Next-state logic: frame parsing, checksum, word assembly and write strobe
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        csum_d       = csum_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        buf_d        = buf_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        accept       = rx_valid && rx_ready;
        len_full     = {rx_data, len_q[7:0]};
        word_cnt_inc = word_cnt_q + 1'b1;

        if (accept) begin
            csum_d = csum_q ^ rx_data;
        end

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StLen0;
                    len_d      = '0;
                    csum_d     = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                end
            end
            StLen0: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    if ({1'b0, len_full} > MaxLen) begin
                        state_d = StError;
                    end else if (len_full == 16'd0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: buf_d[7:0]   = rx_data;
                        2'd1: buf_d[15:8]  = rx_data;
                        2'd2: buf_d[23:16] = rx_data;
                        default: begin
                            we_d       = 1'b1;
                            addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                            wdata_d    = {rx_data, buf_q};
                            word_cnt_d = word_cnt_inc;
                            // len <= 2**ADDR_WIDTH here, so its upper bits are zero
                            if (word_cnt_inc == len_q[ADDR_WIDTH:0]) begin
                                state_d = StCheck;
                            end
                        end
                    endcase
                end
            end
            StCheck: begin
                // csum_q still excludes the checksum byte itself
                if (accept) begin
                    state_d = (rx_data == csum_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset also drops any pending imem write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            csum_q     <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good frame, bad checksum, oversize length,
// empty frame, reset mid-load and a throttled stream with a stray start.

module tb_imem_loader;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [7:0]    frame_q[$];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Each high cycle of imem_we counts as one write
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte, wait (bounded) for acceptance, then idle for gap cycles
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
        int n = 0;
        @(negedge clk);
        start    = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (poke_start && g == 0) start = 1'b1;
        end
    endtask

    task automatic send_frame(input int gap, input int poke_idx);
        foreach (frame_q[i]) send_byte(frame_q[i], gap, (i == poke_idx));
        start = 1'b0;
    endtask

    task automatic load_t1_frame(input logic [7:0] csum);
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h93, 8'h00, 8'h10, 8'h00};
        frame_q.push_back(csum);
    endtask

    task automatic check_t1_writes(input string pfx);
        check({pfx, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check({pfx, "_a0"}, 32'(wr_addr_q[0]), 32'd0);
            check({pfx, "_d0"}, wr_data_q[0], 32'h0000_0013);
            check({pfx, "_a1"}, 32'(wr_addr_q[1]), 32'd1);
            check({pfx, "_d1"}, wr_data_q[1], 32'h0010_0093);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_ready", 32'(rx_ready), 32'd0);

        // T1: good two-word frame; 02^13^93^10 = 0x92
        clear_log();
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_core_reset_load", 32'(core_reset), 32'd1);
        load_t1_frame(8'h92);
        send_frame(0, -1);
        @(negedge clk);
        check_t1_writes("t1");
        check("t1_done", 32'(done), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_core_reset", 32'(core_reset), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_rx_ready_end", 32'(rx_ready), 32'd0);

        // T2: same data, wrong checksum
        clear_log();
        pulse_start();
        check("t2_done_cleared", 32'(done), 32'd0);
        load_t1_frame(8'h81);
        send_frame(0, -1);
        @(negedge clk);
        check_t1_writes("t2");
        check("t2_error", 32'(error), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        check("t2_core_reset", 32'(core_reset), 32'd1);

        // T3: LEN = 0x0401 exceeds the 1024-word imem
        clear_log();
        pulse_start();
        check("t3_error_cleared", 32'(error), 32'd0);
        frame_q = '{8'h01, 8'h04};
        send_frame(0, -1);
        @(negedge clk);
        check("t3_error", 32'(error), 32'd1);
        check("t3_rx_ready", 32'(rx_ready), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_nwr", 32'(wr_addr_q.size()), 32'd0);

        // Boundary: LEN = 0x0400 is legal, so the loader must wait in DATA
        pulse_start();
        frame_q = '{8'h00, 8'h04};
        send_frame(0, -1);
        @(negedge clk);
        check("len_max_ready", 32'(rx_ready), 32'd1);
        check("len_max_error", 32'(error), 32'd0);

        // T4: empty frame, checksum 00
        clear_log();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(0, -1);
        @(negedge clk);
        check("t4_done", 32'(done), 32'd1);
        check("t4_core_reset", 32'(core_reset), 32'd0);
        check("t4_nwr", 32'(wr_addr_q.size()), 32'd0);

        // T5: reset after byte 2 of the first data word
        clear_log();
        pulse_start();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        send_frame(0, -1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_rx_ready", 32'(rx_ready), 32'd0);
        check("t5_we", 32'(imem_we), 32'd0);
        check("t5_addr", 32'(imem_addr), 32'd0);
        check("t5_wdata", imem_wdata, 32'd0);
        check("t5_core_reset", 32'(core_reset), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_error", 32'(error), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("t5_nwr", 32'(wr_addr_q.size()), 32'd0);
        clear_log();
        pulse_start();
        load_t1_frame(8'h92);
        send_frame(0, -1);
        @(negedge clk);
        check_t1_writes("t5r");
        check("t5r_done", 32'(done), 32'd1);

        // T6: valid every other cycle, stray start pulsed mid-DATA
        clear_log();
        pulse_start();
        load_t1_frame(8'h92);
        send_frame(1, 4);
        @(negedge clk);
        check_t1_writes("t6");
        check("t6_done", 32'(done), 32'd1);
        check("t6_core_reset", 32'(core_reset), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case a wait goes wrong
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
